pid_pwm_actuator: RTL and testbench
===================================

Name: pid_pwm_actuator

Overview:
- Actuator-side consumer of the PID loop: accepts the signed control word u, converts it to a sign/magnitude PWM drive (pwm + dir), and paces the loop.
- Emits a one-cycle sample_tick at every PWM period start; the controller uses it as its update strobe.
- New u values are double-buffered: taken by valid/ready handshake into a shadow register, applied only at a period boundary.
- Enforces saturation, a deadband, and dead time on direction reversal.

Parameters:
- W, 6, width of u (two's complement); period = 2^(W-1) ticks (32 at default).
- PRESCALE, 2, clocks per PWM tick (>=1).
- DEADBAND, 0, magnitudes < DEADBAND are treated as 0.
- DEAD_TICKS, 2, forced-low ticks at the start of a period in which dir changes (< 2^(W-1)).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- ena  input  1  block enable, same meaning as the rest of the PID datapath.
- u  input  W  signed control word from the PID adder.
- u_valid  input  1  u is valid this cycle.
- u_ready  output  1  shadow register empty and ena=1; transfer happens when u_valid & u_ready.
- pwm  output  1  registered PWM drive.
- dir  output  1  registered direction: 0 = positive u, 1 = negative u.
- sample_tick  output  1  registered one-cycle pulse on the first clock of each period.
- duty  output  W-1  registered active magnitude after saturation and deadband (observability).

Behaviour:
- Reset (rst=1 at a clock edge):
  - pwm=0, dir=0, sample_tick=0, duty=0.
  - Shadow cleared; prescaler and period counter set to 0; state=IDLE.
  - Reset mid-period aborts the period immediately; outputs are 0 from the cycle after the reset edge.
- Magnitude rule:
  - mag = |u|, saturated to 2^(W-1)-1. At default W, -32 gives 31 and +31 gives 31.
  - If mag < DEADBAND then mag = 0.
  - sign = u[W-1], except that u=0 (or a deadbanded value) keeps the previous dir.
- Timing:
  - A tick occurs every PRESCALE clocks.
  - The period counter cnt runs 0 to 2^(W-1)-1, one step per tick.
  - Boundary event B = the last clock of the tick where cnt = max.
- State machine, IDLE / RUN / DEAD:
  - IDLE: entered while ena=0; pwm=0; counters held at 0; u_ready=0; shadow retained.
  - IDLE -> RUN on ena=1; the first period starts the next cycle, with sample_tick=1 on that cycle.
  - RUN -> DEAD at B when the newly loaded sign differs from dir and the new mag is non-zero; dir updates at that same boundary.
  - DEAD: pwm=0 for ticks 0 .. DEAD_TICKS-1, then -> RUN for the rest of the period.
  - Any state -> IDLE when ena=0: pwm=0 the next cycle; the period is abandoned.
- PWM output: in RUN, pwm=1 exactly during ticks k with k < duty, i.e. duty*PRESCALE clocks starting at the period's first clock.
  - In DEAD, high ticks are those with DEAD_TICKS <= k < duty.
  - duty=0 means pwm is low for the whole period.
- Buffer and handshake:
  - At B, if the shadow is full, its value loads into active and the shadow empties; otherwise active is kept.
  - If a transfer occurs on the same cycle as B, the incoming u loads active directly and the shadow stays empty.
  - While the shadow is full, u_ready=0; further u_valid is stalled, not dropped.
- sample_tick: high on the first clock of every period (the cycle after B, and the first cycle after entering RUN); never high in IDLE.
- Latency: a u accepted at least one clock before B is reflected on pwm, dir and duty from the first clock of the next period.

Decomposition:
- Shared PID package:
  - W default and derived PERIOD = 2^(W-1).
  - Saturation max constant.
  - State enum {IDLE, RUN, DEAD}.
- One natural sub-module: pid_tick_gen, a prescaler producing the tick strobe with synchronous clear on rst or ena=0.

Test Plan (W=6, PRESCALE=2, DEAD_TICKS=2, DEADBAND=0 unless noted; period = 64 clocks):
- Hold rst=1 for 3 clocks with ena=1 and u_valid=1 -> pwm=0, dir=0, sample_tick=0, duty=0; after release the first sample_tick comes 1 clock later and there are no transfers during reset.
- Send u=+8 before the first B -> next period: duty=8, dir=0, pwm high 16 clocks then low 48; sample_tick every 64 clocks.
- From the u=+8 steady state, send u=-32 -> duty=31, dir=1 at the boundary; pwm low 4 clocks (dead), high 58, low 2; the following period is high 62 clocks with no dead time.
- DEADBAND=3, send u=+2 after a period with dir=1 -> duty=0, pwm low all 64 clocks, dir stays 1.
- Two u_valid pulses (+4 then +12) within one period -> the second waits with u_ready=0 until B. Next period duty=4, then duty=12; a transfer landing exactly on B applies with no extra period delay.
- Deassert ena mid-period, re-assert after 10 clocks -> pwm=0 the cycle after ena falls, sample_tick fires 1 clock after re-enable, and the duty is resumed from the retained active value. Pulse rst mid-period -> outputs 0 the next cycle and the shadow is empty.

Source files
------------

// File: rtl/pid_pwm_actuator_pkg.sv
// Shared constants and state encoding for the PID actuator-side PWM stage.
package pid_pwm_actuator_pkg;

    localparam int W_DEFAULT       = 6;
    localparam int PERIOD_DEFAULT  = 2 ** (W_DEFAULT - 1);
    localparam int SAT_MAX_DEFAULT = PERIOD_DEFAULT - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } pwm_state_t;

    // Largest magnitude a W-bit two's complement word maps to on the PWM.
    function automatic int sat_max(input int w);
        return (2 ** (w - 1)) - 1;
    endfunction

endpackage

// File: rtl/pid_tick_gen.sv
// Prescaler: tick is high on the last clock of every PRESCALE-clock tick.
module pid_tick_gen #(
    parameter int PRESCALE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic hold,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic          clr;
    logic [PW-1:0] pcnt_reg;

    assign clr  = rst || !ena || hold;
    assign tick = (pcnt_reg == LAST) && !clr;

    always_ff @(posedge clk) begin
        if (clr) begin
            pcnt_reg <= '0;
        end else if (pcnt_reg == LAST) begin
            pcnt_reg <= '0;
        end else begin
            pcnt_reg <= pcnt_reg + PW'(1);
        end
    end

endmodule

// File: rtl/pid_pwm_actuator.sv
// Converts the signed PID control word into sign/magnitude PWM with a
// double-buffered update at period boundaries and dead time on reversal.
module pid_pwm_actuator
    import pid_pwm_actuator_pkg::*;
#(
    parameter int W          = W_DEFAULT,
    parameter int PRESCALE   = 2,
    parameter int DEADBAND   = 0,
    parameter int DEAD_TICKS = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [W-1:0] u,
    input  logic         u_valid,
    output logic         u_ready,
    output logic         pwm,
    output logic         dir,
    output logic         sample_tick,
    output logic [W-2:0] duty
);

    localparam logic [W-2:0] SAT_MAX  = (W - 1)'(sat_max(W));
    localparam logic [W-2:0] DB       = (W - 1)'(DEADBAND);
    localparam logic [W-2:0] DT       = (W - 1)'(DEAD_TICKS);
    localparam bit           HAS_DEAD = (DEAD_TICKS > 0);

    pwm_state_t   state_reg, state_next;
    logic [W-2:0] cnt_reg, cnt_next;
    logic [W-2:0] duty_reg, duty_next;
    logic         dir_reg, dir_next;
    logic         pwm_reg, pwm_next;
    logic         sample_reg, sample_next;
    logic         shadow_full_reg, shadow_full_next;
    logic [W-1:0] shadow_u_reg, shadow_u_next;

    logic         tick;
    logic         xfer;
    logic         boundary;
    logic [W-1:0] load_u;
    logic [W-1:0] abs_u;
    logic [W-2:0] mag_raw;
    logic [W-2:0] mag;
    logic         new_sign;

    pid_tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .hold(state_reg == IDLE),
        .tick(tick)
    );

    assign u_ready  = ena && !rst && !shadow_full_reg && (state_reg != IDLE);
    assign xfer     = u_valid && u_ready;
    assign boundary = (state_reg != IDLE) && tick && (cnt_reg == SAT_MAX);

    // A word arriving exactly on the boundary bypasses the shadow.
    always_comb begin
        load_u   = xfer ? u : shadow_u_reg;
        abs_u    = load_u[W-1] ? (~load_u + W'(1)) : load_u;
        mag_raw  = abs_u[W-1] ? SAT_MAX : abs_u[W-2:0];
        mag      = (mag_raw < DB) ? '0 : mag_raw;
        new_sign = load_u[W-1];
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        duty_next        = duty_reg;
        dir_next         = dir_reg;
        shadow_full_next = shadow_full_reg;
        shadow_u_next    = shadow_u_reg;
        pwm_next         = 1'b0;
        sample_next      = 1'b0;
        if (!ena) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else if (state_reg == IDLE) begin
            state_next  = RUN;
            cnt_next    = '0;
            sample_next = 1'b1;
            pwm_next    = (duty_reg != '0);
        end else begin
            if (tick) begin
                cnt_next = cnt_reg + (W - 1)'(1);
            end
            if (boundary) begin
                sample_next = 1'b1;
                state_next  = RUN;
                if (xfer || shadow_full_reg) begin
                    duty_next        = mag;
                    shadow_full_next = 1'b0;
                    // Zero or deadbanded words keep the previous direction.
                    if (mag != '0) begin
                        dir_next = new_sign;
                        if (HAS_DEAD && (new_sign != dir_reg)) begin
                            state_next = DEAD;
                        end
                    end
                end
            end else begin
                if (xfer) begin
                    shadow_full_next = 1'b1;
                    shadow_u_next    = u;
                end
                if ((state_reg == DEAD) && tick && (cnt_next == DT)) begin
                    state_next = RUN;
                end
            end
            pwm_next = (state_next == RUN) && (cnt_next < duty_next);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            duty_reg        <= '0;
            dir_reg         <= 1'b0;
            pwm_reg         <= 1'b0;
            sample_reg      <= 1'b0;
            shadow_full_reg <= 1'b0;
            shadow_u_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            duty_reg        <= duty_next;
            dir_reg         <= dir_next;
            pwm_reg         <= pwm_next;
            sample_reg      <= sample_next;
            shadow_full_reg <= shadow_full_next;
            shadow_u_reg    <= shadow_u_next;
        end
    end

    assign pwm         = pwm_reg;
    assign dir         = dir_reg;
    assign sample_tick = sample_reg;
    assign duty        = duty_reg;

endmodule

// File: tb/tb_pid_pwm_actuator.sv
// Directed bench: two actuators (deadband 0 and 3) share the same stimulus.
module tb_pid_pwm_actuator;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [5:0] u;
    logic       u_valid;

    logic       u_ready, pwm, dir, sample_tick;
    logic [4:0] duty;
    logic       u_ready_db, pwm_db, dir_db, sample_tick_db;
    logic [4:0] duty_db;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pid_pwm_actuator #(.W(6), .PRESCALE(2), .DEADBAND(0), .DEAD_TICKS(2)) dut (
        .clk(clk), .rst(rst), .ena(ena), .u(u), .u_valid(u_valid),
        .u_ready(u_ready), .pwm(pwm), .dir(dir), .sample_tick(sample_tick), .duty(duty)
    );

    pid_pwm_actuator #(.W(6), .PRESCALE(2), .DEADBAND(3), .DEAD_TICKS(2)) dut_db (
        .clk(clk), .rst(rst), .ena(ena), .u(u), .u_valid(u_valid),
        .u_ready(u_ready_db), .pwm(pwm_db), .dir(dir_db), .sample_tick(sample_tick_db), .duty(duty_db)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; drop u_valid once the handshake completes.
    task automatic step();
        logic acc;
        acc = u_valid && u_ready;
        @(posedge clk);
        #1;
        if (acc) u_valid = 1'b0;
    endtask

    task automatic send(input string tag, input logic [5:0] val, input logic exp_rdy);
        u       = val;
        u_valid = 1'b1;
        chk({tag, "_ready"}, u_ready, exp_rdy);
        chk({tag, "_ready_db"}, u_ready_db, exp_rdy);
    endtask

    // Walk period positions i0..i1-1, checking pwm against [lo,hi) windows.
    task automatic run_seg(input string tag, input int i0, input int i1,
                           input int lo, input int hi, input int lo_db, input int hi_db,
                           input logic edir, input logic edir_db,
                           input int eduty, input int eduty_db);
        int bad    = 0;
        int bad_db = 0;
        int bad_t  = 0;
        chk({tag, "_dir"}, dir, edir);
        chk({tag, "_dir_db"}, dir_db, edir_db);
        chk({tag, "_duty"}, duty, eduty);
        chk({tag, "_duty_db"}, duty_db, eduty_db);
        for (int i = i0; i < i1; i++) begin
            if (pwm !== (i >= lo && i < hi)) bad++;
            if (pwm_db !== (i >= lo_db && i < hi_db)) bad_db++;
            if (sample_tick !== (i == 0) || sample_tick_db !== (i == 0)) bad_t++;
            step();
        end
        chk({tag, "_pwm_bad_clocks"}, bad, 0);
        chk({tag, "_pwm_db_bad_clocks"}, bad_db, 0);
        chk({tag, "_tick_bad_clocks"}, bad_t, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        rst     = 1'b1;
        ena     = 1'b1;
        u       = 6'd9;
        u_valid = 1'b1;

        // Reset held for 3 clocks with a valid word offered.
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_ready", u_ready, 1'b0);
        end
        chk("rst_pwm", pwm, 1'b0);
        chk("rst_dir", dir, 1'b0);
        chk("rst_tick", sample_tick, 1'b0);
        chk("rst_duty", duty, 5'd0);
        rst     = 1'b0;
        u_valid = 1'b0;
        step();
        chk("first_tick", sample_tick, 1'b1);

        // P0: nothing loaded; +8 accepted mid-period.
        run_seg("p0a", 0, 5, 0, 0, 0, 0, 1'b0, 1'b0, 0, 0);
        send("p0_send", 6'd8, 1'b1);
        run_seg("p0b", 5, 64, 0, 0, 0, 0, 1'b0, 1'b0, 0, 0);

        // P1: duty 8 -> 16 clocks high; queue -32.
        run_seg("p1a", 0, 30, 0, 16, 0, 16, 1'b0, 1'b0, 8, 8);
        send("p1_send", 6'b100000, 1'b1);
        run_seg("p1b", 30, 64, 0, 16, 0, 16, 1'b0, 1'b0, 8, 8);

        // P2: reversal, saturated: 4 dead clocks, high to clock 61.
        run_seg("p2", 0, 64, 4, 62, 4, 62, 1'b1, 1'b1, 31, 31);

        // P3: no dead time; queue +2.
        run_seg("p3a", 0, 10, 0, 62, 0, 62, 1'b1, 1'b1, 31, 31);
        send("p3_send", 6'd2, 1'b1);
        run_seg("p3b", 10, 64, 0, 62, 0, 62, 1'b1, 1'b1, 31, 31);

        // P4: +2 reverses the plain unit (dead covers it) but is deadbanded on
        // the other, which keeps dir=1. Two words offered; the second stalls.
        run_seg("p4a", 0, 10, 0, 0, 0, 0, 1'b0, 1'b1, 2, 0);
        send("p4_send1", 6'd4, 1'b1);
        run_seg("p4b", 10, 20, 0, 0, 0, 0, 1'b0, 1'b1, 2, 0);
        send("p4_send2", 6'd12, 1'b0);
        run_seg("p4c", 20, 64, 0, 0, 0, 0, 1'b0, 1'b1, 2, 0);

        // P5: duty 4; deadband unit reverses here and sees dead time.
        run_seg("p5a", 0, 1, 0, 8, 4, 8, 1'b0, 1'b0, 4, 4);
        chk("p5_ready_after_stall", u_ready, 1'b0);
        chk("p5_ready_after_stall_db", u_ready_db, 1'b0);
        run_seg("p5b", 1, 64, 0, 8, 4, 8, 1'b0, 1'b0, 4, 4);

        // P6: duty 12; a word transferred exactly on the boundary.
        run_seg("p6a", 0, 63, 0, 24, 0, 24, 1'b0, 1'b0, 12, 12);
        send("p6_send_b", 6'd20, 1'b1);
        run_seg("p6b", 63, 64, 0, 24, 0, 24, 1'b0, 1'b0, 12, 12);

        // P7: duty 20 straight away; then disable for 10 clocks.
        run_seg("p7", 0, 30, 0, 40, 0, 40, 1'b0, 1'b0, 20, 20);
        ena = 1'b0;
        step();
        chk("dis_pwm", pwm, 1'b0);
        chk("dis_tick", sample_tick, 1'b0);
        chk("dis_ready", u_ready, 1'b0);
        chk("dis_duty", duty, 5'd20);
        bad = 0;
        for (int k = 0; k < 9; k++) begin
            step();
            if (pwm !== 1'b0 || sample_tick !== 1'b0 || pwm_db !== 1'b0) bad++;
        end
        chk("dis_idle_bad_clocks", bad, 0);
        ena = 1'b1;
        step();
        chk("reen_tick", sample_tick, 1'b1);
        run_seg("p8", 0, 64, 0, 40, 0, 40, 1'b0, 1'b0, 20, 20);

        // P9: fill the shadow, then reset mid-period.
        run_seg("p9", 0, 20, 0, 40, 0, 40, 1'b0, 1'b0, 20, 20);
        send("p9_send", 6'd4, 1'b1);
        step();
        rst = 1'b1;
        step();
        chk("mid_rst_pwm", pwm, 1'b0);
        chk("mid_rst_duty", duty, 5'd0);
        chk("mid_rst_dir", dir, 1'b0);
        chk("mid_rst_tick", sample_tick, 1'b0);
        rst = 1'b0;
        step();
        chk("post_rst_tick", sample_tick, 1'b1);
        chk("post_rst_ready", u_ready, 1'b1);
        run_seg("p10", 0, 64, 0, 0, 0, 0, 1'b0, 1'b0, 0, 0);
        run_seg("p11", 0, 64, 0, 0, 0, 0, 1'b0, 1'b0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
